riscv_mem_arbiter: RTL and testbench

- Shares one 128-bit refill/writeback memory port between the data-cache FSM (read/write) and the instruction-cache FSM (read-only).
- Sits in riscv_top between riscv_core's dmem/imem refill ports and a single unified DRAM model, replacing the separate DRAM and IRAM instances.
- Fixed priority goes to dcache, with a starvation limit that protects icache. Each memory transaction is latched and held until the memory returns ready.

---
 rtl/riscv_arb_pkg.sv | 23 ++
 rtl/riscv_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_arb_pkg
// Description : Shared types and defaults for the refill memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_D_BUSY = 2'b01,
        ST_I_BUSY = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWNER_D = 1'b0,
        OWNER_I = 1'b1
    } arb_owner_e;

    localparam int unsigned C_STARVE_LIM_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_arbiter
// Description : Shares one refill/writeback memory port between dcache and
//               icache; dcache priority with an icache starvation limit.
//               Define RISCV_ARB_PERF_EN to add grant/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned S_ADDR     = 10,
    parameter int unsigned STARVE_LIM = C_STARVE_LIM_DEF
) (
    input  logic                  i_riscv_arb_clk,
    input  logic                  i_riscv_arb_rst_n,
    input  logic                  i_riscv_arb_d_rden,
    input  logic                  i_riscv_arb_d_wren,
    input  logic [S_ADDR-1:0]     i_riscv_arb_d_addr,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_d_wdata,
    output logic                  o_riscv_arb_d_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_d_rdata,
    input  logic                  i_riscv_arb_i_rden,
    input  logic [S_ADDR-1:0]     i_riscv_arb_i_addr,
    output logic                  o_riscv_arb_i_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_i_rdata,
    output logic                  o_riscv_arb_mem_rden,
    output logic                  o_riscv_arb_mem_wren,
    output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata,
    input  logic                  i_riscv_arb_mem_ready,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_rdata
`ifdef RISCV_ARB_PERF_EN
    ,
    output logic [31:0]           o_riscv_arb_d_grants,
    output logic [31:0]           o_riscv_arb_i_grants,
    output logic [31:0]           o_riscv_arb_stall_cyc
`endif
);

    localparam logic [3:0] C_STARVE_LIM = 4'(STARVE_LIM);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst_n) begin
        if (!i_riscv_arb_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [3:0]            r_starve;
    logic                  r_mem_rden;
    logic                  r_mem_wren;
    logic [S_ADDR-1:0]     r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic                  w_d_req;
    logic                  w_d_grant;
    logic                  w_i_grant;
    logic                  w_busy_done;
    logic                  w_d_ready;
    logic                  w_i_ready;

    always_comb begin
        w_d_req     = i_riscv_arb_d_rden | i_riscv_arb_d_wren;
        w_d_grant   = 1'b0;
        w_i_grant   = 1'b0;
        w_busy_done = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_d_req && (!i_riscv_arb_i_rden || (r_starve < C_STARVE_LIM))) begin
                    w_d_grant   = 1'b1;
                    w_state_nxt = ST_D_BUSY;
                end else if (i_riscv_arb_i_rden) begin
                    w_i_grant   = 1'b1;
                    w_state_nxt = ST_I_BUSY;
                end
            end
            ST_D_BUSY, ST_I_BUSY: begin
                if (i_riscv_arb_mem_ready) begin
                    w_busy_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_d_ready = i_riscv_arb_mem_ready && (r_state == ST_D_BUSY);
    assign w_i_ready = i_riscv_arb_mem_ready && (r_state == ST_I_BUSY);

    always_ff @(posedge i_riscv_arb_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_starve    <= 4'd0;
            r_mem_rden  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_d_rdata   <= '0;
            r_i_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_d_grant) begin
                // A simultaneous read+write request is issued as a write only.
                r_mem_wren  <= i_riscv_arb_d_wren;
                r_mem_rden  <= ~i_riscv_arb_d_wren;
                r_mem_addr  <= i_riscv_arb_d_addr;
                r_mem_wdata <= i_riscv_arb_d_wdata;
                if (!i_riscv_arb_i_rden) begin
                    r_starve <= 4'd0;
                end else if (r_starve < C_STARVE_LIM) begin
                    r_starve <= r_starve + 4'd1;
                end
            end else if (w_i_grant) begin
                r_mem_wren  <= 1'b0;
                r_mem_rden  <= 1'b1;
                r_mem_addr  <= i_riscv_arb_i_addr;
                r_mem_wdata <= '0;
                r_starve    <= 4'd0;
            end else if (w_busy_done) begin
                r_mem_wren <= 1'b0;
                r_mem_rden <= 1'b0;
            end
            if (w_d_ready) begin
                r_d_rdata <= i_riscv_arb_mem_rdata;
            end
            if (w_i_ready) begin
                r_i_rdata <= i_riscv_arb_mem_rdata;
            end
        end
    end

    assign o_riscv_arb_mem_rden  = r_mem_rden;
    assign o_riscv_arb_mem_wren  = r_mem_wren;
    assign o_riscv_arb_mem_addr  = r_mem_addr;
    assign o_riscv_arb_mem_wdata = r_mem_wdata;
    assign o_riscv_arb_d_ready   = w_d_ready;
    assign o_riscv_arb_i_ready   = w_i_ready;
    // Owner sees memory data live; the other side keeps its last response.
    assign o_riscv_arb_d_rdata   = w_d_ready ? i_riscv_arb_mem_rdata : r_d_rdata;
    assign o_riscv_arb_i_rdata   = w_i_ready ? i_riscv_arb_mem_rdata : r_i_rdata;

`ifdef RISCV_ARB_PERF_EN
    logic [31:0] r_d_grants;
    logic [31:0] r_i_grants;
    logic [31:0] r_stall_cyc;
    logic        w_stall;

    // A requester already being served is not counted as waiting.
    assign w_stall = (w_d_req && (r_state != ST_D_BUSY) && !w_d_grant) ||
                     (i_riscv_arb_i_rden && (r_state != ST_I_BUSY) && !w_i_grant);

    always_ff @(posedge i_riscv_arb_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_d_grants  <= 32'd0;
            r_i_grants  <= 32'd0;
            r_stall_cyc <= 32'd0;
        end else begin
            if (w_d_grant) begin
                r_d_grants <= r_d_grants + 32'd1;
            end
            if (w_i_grant) begin
                r_i_grants <= r_i_grants + 32'd1;
            end
            if (w_stall) begin
                r_stall_cyc <= r_stall_cyc + 32'd1;
            end
        end
    end

    assign o_riscv_arb_d_grants  = r_d_grants;
    assign o_riscv_arb_i_grants  = r_i_grants;
    assign o_riscv_arb_stall_cyc = r_stall_cyc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_mem_arbiter
// Description : Scoreboard bench for riscv_mem_arbiter with a latency memory
//               model; counter checks enabled when RISCV_ARB_PERF_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;

    localparam int c_DW  = 128;
    localparam int c_AW  = 10;
    localparam int c_LIM = 4;
    localparam int c_LAT = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            d_rden = 1'b0, d_wren = 1'b0;
    logic [c_AW-1:0] d_addr = '0;
    logic [c_DW-1:0] d_wdata = '0;
    logic            d_ready;
    logic [c_DW-1:0] d_rdata;
    logic            i_rden = 1'b0;
    logic [c_AW-1:0] i_addr = '0;
    logic            i_ready;
    logic [c_DW-1:0] i_rdata;
    logic            mem_rden, mem_wren;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata;
    logic            mem_ready = 1'b0;
    logic [c_DW-1:0] mem_rdata = '0;
`ifdef RISCV_ARB_PERF_EN
    logic [31:0]     d_grants, i_grants, stall_cyc;
`endif

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.DATA_WIDTH(c_DW), .S_ADDR(c_AW), .STARVE_LIM(c_LIM)) u_dut (
        .i_riscv_arb_clk       (clk),
        .i_riscv_arb_rst_n     (rst_n),
        .i_riscv_arb_d_rden    (d_rden),
        .i_riscv_arb_d_wren    (d_wren),
        .i_riscv_arb_d_addr    (d_addr),
        .i_riscv_arb_d_wdata   (d_wdata),
        .o_riscv_arb_d_ready   (d_ready),
        .o_riscv_arb_d_rdata   (d_rdata),
        .i_riscv_arb_i_rden    (i_rden),
        .i_riscv_arb_i_addr    (i_addr),
        .o_riscv_arb_i_ready   (i_ready),
        .o_riscv_arb_i_rdata   (i_rdata),
        .o_riscv_arb_mem_rden  (mem_rden),
        .o_riscv_arb_mem_wren  (mem_wren),
        .o_riscv_arb_mem_addr  (mem_addr),
        .o_riscv_arb_mem_wdata (mem_wdata),
        .i_riscv_arb_mem_ready (mem_ready),
        .i_riscv_arb_mem_rdata (mem_rdata)
`ifdef RISCV_ARB_PERF_EN
        ,
        .o_riscv_arb_d_grants  (d_grants),
        .o_riscv_arb_i_grants  (i_grants),
        .o_riscv_arb_stall_cyc (stall_cyc)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_DW-1:0] mem_data(input logic [c_AW-1:0] a);
        return {16{a[7:0] ^ 8'hB7}};
    endfunction

    typedef struct {
        logic            wr;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] wdata;
    } txn_t;

    txn_t            exp_q[$];
    logic [c_DW-1:0] last_d_rdata = '0;
    logic [c_DW-1:0] last_i_rdata = '0;

    // Memory model: accepts a strobe, holds for c_LAT cycles, then pulses ready.
    bit   resp_en = 1'b1;
    bit   busy = 1'b0;
    int   cnt = 0;
    txn_t cur;

    always begin
        @(posedge clk);
        #1;
        if (!resp_en) begin
            // stimulus drives the memory side directly
        end else if (!rst_n) begin
            busy      = 1'b0;
            mem_ready = 1'b0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            check("strobe_gap", {mem_rden, mem_wren}, 2'b00);
        end else if (busy) begin
            check("mem_addr_hold", mem_addr, cur.addr);
            check("mem_dir_hold", {mem_wren, mem_rden}, {cur.wr, !cur.wr});
            cnt--;
            if (cnt == 0) begin
                mem_ready = 1'b1;
                if (!cur.wr) mem_rdata = mem_data(cur.addr);
                busy = 1'b0;
            end
        end else if (mem_rden || mem_wren) begin
            if (exp_q.size() == 0) begin
                check("unexpected_txn", {mem_wren, mem_rden, mem_addr}, '0);
                cur.wr = mem_wren; cur.addr = mem_addr; cur.wdata = mem_wdata;
            end else begin
                cur = exp_q.pop_front();
                check("mem_dir", {mem_wren, mem_rden}, {cur.wr, !cur.wr});
                check("mem_addr", mem_addr, cur.addr);
                if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
            end
            busy = 1'b1;
            cnt  = c_LAT;
        end
    end

    task automatic push(input logic wr, input logic [c_AW-1:0] a, input logic [c_DW-1:0] wd);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = wd;
        exp_q.push_back(t);
    endtask

    // Holds the dcache request level across n back-to-back transactions.
    task automatic d_req(input logic wr, input logic rd, input logic [c_AW-1:0] a,
                         input logic [c_DW-1:0] wd, input int n, input bit chg);
        bit got;
        @(posedge clk); #1;
        d_wren = wr; d_rden = rd; d_addr = a; d_wdata = wd;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                if (d_ready) got = 1'b1;
                if (chg && t == 2) d_addr = 10'h3FF;
            end
            check("d_ready_seen", got, 1'b1);
            if (got) begin
                check("i_ready_excl", i_ready, 1'b0);
                last_d_rdata = wr ? mem_rdata : mem_data(a + c_AW'(k));
                check("d_rdata", d_rdata, last_d_rdata);
                check("i_rdata_hold", i_rdata, last_i_rdata);
            end
            @(posedge clk); #1;
            if (k < n - 1) d_addr = a + c_AW'(k + 1);
        end
        d_wren = 1'b0; d_rden = 1'b0;
    endtask

    task automatic i_req(input logic [c_AW-1:0] a);
        bit got;
        @(posedge clk); #1;
        i_rden = 1'b1; i_addr = a;
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (i_ready) got = 1'b1;
        end
        check("i_ready_seen", got, 1'b1);
        if (got) begin
            check("d_ready_excl", d_ready, 1'b0);
            last_i_rdata = mem_data(a);
            check("i_rdata", i_rdata, last_i_rdata);
            check("d_rdata_hold", d_rdata, last_d_rdata);
        end
        @(posedge clk); #1;
        i_rden = 1'b0;
    endtask

`ifdef RISCV_ARB_PERF_EN
    // Independent tally of cycles where some requester waits without a grant.
    int m_st = 0;
    int m_stv = 0;
    int m_stall = 0;
    always @(negedge clk) begin
        bit dq, dg, ig;
        if (!rst_n) begin
            m_st = 0; m_stv = 0; m_stall = 0;
        end else begin
            dq = d_rden | d_wren;
            dg = (m_st == 0) && dq && (!i_rden || m_stv < c_LIM);
            ig = (m_st == 0) && i_rden && !dg;
            if ((dq && m_st != 1 && !dg) || (i_rden && m_st != 2 && !ig)) m_stall++;
            if (dg) begin
                m_st = 1;
                m_stv = !i_rden ? 0 : (m_stv < c_LIM ? m_stv + 1 : m_stv);
            end else if (ig) begin
                m_st = 2; m_stv = 0;
            end else if (m_st != 0 && mem_ready) begin
                m_st = 0;
            end
        end
    end
`endif

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rden", mem_rden, 1'b0);
        check("rst_mem_wren", mem_wren, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_ready", {d_ready, i_ready}, 2'b00);
        check("rst_d_rdata", d_rdata, '0);
        check("rst_i_rdata", i_rdata, '0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // dcache read with request-to-strobe latency of one cycle
        push(1'b0, 10'h012, '0);
        fork
            d_req(1'b0, 1'b1, 10'h012, '0, 1, 1'b0);
            begin
                @(posedge clk); #2;
                check("strobe_before_grant", mem_rden, 1'b0);
                @(posedge clk); #2;
                check("strobe_latency", {mem_rden, mem_addr}, {1'b1, 10'h012});
            end
        join
        check("d_rdata_a5", last_d_rdata, {16{8'hA5}});

        // simultaneous dcache write and icache read
        push(1'b1, 10'h020, {16{8'h11}});
        push(1'b0, 10'h030, '0);
        fork
            d_req(1'b1, 1'b0, 10'h020, {16{8'h11}}, 1, 1'b0);
            i_req(10'h030);
        join

        // read and write together issue a write only
        push(1'b1, 10'h055, {4{32'hDEADBEEF}});
        d_req(1'b1, 1'b1, 10'h055, {4{32'hDEADBEEF}}, 1, 1'b0);

        // starvation: four dcache grants, then icache, then dcache resumes
        for (int k = 0; k < 4; k++) push(1'b0, 10'h100 + c_AW'(k), '0);
        push(1'b0, 10'h1A0, '0);
        push(1'b0, 10'h104, '0);
        fork
            d_req(1'b0, 1'b1, 10'h100, '0, 5, 1'b0);
            i_req(10'h1A0);
        join

        // requester address change while busy
        push(1'b0, 10'h040, '0);
        d_req(1'b0, 1'b1, 10'h040, '0, 1, 1'b1);

        // async reset in the middle of an icache transfer
        push(1'b0, 10'h2AB, '0);
        @(posedge clk); #1;
        i_rden = 1'b1; i_addr = 10'h2AB;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0; i_rden = 1'b0;
        #1;
        check("async_rst_rden", mem_rden, 1'b0);
        check("async_rst_addr", mem_addr, '0);
        check("async_rst_ready", {d_ready, i_ready}, 2'b00);
        @(posedge clk); #3;
        rst_n = 1'b1;
        last_d_rdata = '0; last_i_rdata = '0;
        repeat (3) @(posedge clk);
        resp_en = 1'b0;
        #1;
        mem_ready = 1'b1; mem_rdata = {c_DW{1'b1}};
        @(negedge clk);
        check("stale_ready", {d_ready, i_ready}, 2'b00);
        check("stale_i_rdata", i_rdata, '0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("stale_no_strobe", {mem_rden, mem_wren}, 2'b00);
        resp_en = 1'b1;

        // recovery traffic after reset
        push(1'b0, 10'h077, '0);
        i_req(10'h077);
        push(1'b0, 10'h111, '0);
        d_req(1'b0, 1'b1, 10'h111, '0, 1, 1'b0);
        push(1'b0, 10'h112, '0);
        d_req(1'b0, 1'b1, 10'h112, '0, 1, 1'b0);
        push(1'b1, 10'h113, {16{8'h5C}});
        push(1'b0, 10'h114, '0);
        fork
            d_req(1'b1, 1'b0, 10'h113, {16{8'h5C}}, 1, 1'b0);
            i_req(10'h114);
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef RISCV_ARB_PERF_EN
        check("perf_d_grants", d_grants, 32'd3);
        check("perf_i_grants", i_grants, 32'd2);
        check("perf_stall_cyc", stall_cyc, 32'(m_stall));
`endif
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
